// File: rtl/proc_pkg.sv
// Shared widths, command-word layout and head-decision encoding for the
// pulse command queue.
package proc_pkg;

  localparam int CMD_WIDTH     = 72;
  localparam int TIME_WIDTH    = 32;
  localparam int PAYLOAD_WIDTH = CMD_WIDTH - TIME_WIDTH;
  localparam int DEPTH_LOG2    = 3;

  // Trigger time occupies the upper bits of the command word.
  typedef struct packed {
    logic [TIME_WIDTH-1:0]    trig_time;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } cmd_t;

  typedef enum logic [1:0] {
    HEAD_IDLE,
    HEAD_HOLD,
    HEAD_ISSUE,
    HEAD_LATE
  } head_act_e;

  // Modular difference read as signed: MSB set means the trigger time is behind qclk.
  function automatic logic time_is_late(input logic [TIME_WIDTH-1:0] diff);
    return diff[TIME_WIDTH-1];
  endfunction

endpackage

// File: rtl/pulse_cmd_fifo_mem.sv
// Register-array storage for the pulse command queue: synchronous write,
// asynchronous read of the current head entry.
module pulse_cmd_fifo_mem #(
  parameter int WIDTH      = 72,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

  // Storage is left unreset; occupancy is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pulse_cmd_queue.sv
// Timed pulse-command queue: buffers core commands in order and releases the
// head when qclk reaches its trigger time. Define PULSE_LATE_ISSUE_EN to issue
// late heads instead of discarding them.
module pulse_cmd_queue
  import proc_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CMD_WIDTH-1:0]     cmd_in_i,
  input  logic                     cstrobe_i,
  input  logic [TIME_WIDTH-1:0]    qclk_i,
  input  logic                     flush_i,
  output logic [PAYLOAD_WIDTH-1:0] pulse_out_o,
  output logic                     pulse_valid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [DEPTH_LOG2:0]      count_o,
  output logic                     overflow_err_o,
  output logic                     late_err_o
);

  logic [DEPTH_LOG2:0]      wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]      rd_ptr_q, rd_ptr_d;
  logic [PAYLOAD_WIDTH-1:0] pulse_out_q, pulse_out_d;
  logic                     pulse_valid_q, pulse_valid_d;
  logic                     overflow_q, overflow_d;
  logic                     late_q, late_d;

  logic [CMD_WIDTH-1:0]     head_word;
  cmd_t                     head_cmd;
  logic [TIME_WIDTH-1:0]    head_diff;
  head_act_e                head_act;
  logic                     empty, full, push, pop;

  pulse_cmd_fifo_mem #(
    .WIDTH      (CMD_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata_i (cmd_in_i),
    .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
    .rdata_o (head_word)
  );

  // Pointers carry an extra wrap bit: equal means empty, MSB-only difference means full.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {DEPTH_LOG2{1'b0}}});
  assign head_cmd  = head_word;
  assign head_diff = head_cmd.trig_time - qclk_i;

  always_comb begin
    head_act = HEAD_IDLE;
    if (!empty && !flush_i) begin
      if (head_diff == '0) begin
        head_act = HEAD_ISSUE;
      end else if (time_is_late(head_diff)) begin
        head_act = HEAD_LATE;
      end else begin
        head_act = HEAD_HOLD;
      end
    end
  end

  assign pop  = (head_act == HEAD_ISSUE) || (head_act == HEAD_LATE);
  assign push = cstrobe_i && !flush_i && (!full || pop);

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pulse_out_d   = pulse_out_q;
    pulse_valid_d = 1'b0;
    overflow_d    = overflow_q;
    late_d        = late_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (cstrobe_i && full && !pop) begin
        overflow_d = 1'b1;
      end

      case (head_act)
        HEAD_ISSUE: begin
          pulse_valid_d = 1'b1;
          pulse_out_d   = head_cmd.payload;
        end
        HEAD_LATE: begin
          late_d = 1'b1;
`ifdef PULSE_LATE_ISSUE_EN
          pulse_valid_d = 1'b1;
          pulse_out_d   = head_cmd.payload;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pulse_out_q   <= '0;
      pulse_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      late_q        <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pulse_out_q   <= pulse_out_d;
      pulse_valid_q <= pulse_valid_d;
      overflow_q    <= overflow_d;
      late_q        <= late_d;
    end
  end

  assign pulse_out_o    = pulse_out_q;
  assign pulse_valid_o  = pulse_valid_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign count_o        = wr_ptr_q - rd_ptr_q;
  assign overflow_err_o = overflow_q;
  assign late_err_o     = late_q;

endmodule

// File: tb/tb_pulse_cmd_queue.sv
// Self-checking bench for pulse_cmd_queue: directed scenarios plus random
// traffic compared every cycle against a queue-based reference model.
module tb_pulse_cmd_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [71:0] cmd_in = '0;
  logic        cstrobe = 1'b0;
  logic [31:0] qclk = '0;
  logic        flush = 1'b0;
  logic [39:0] pulse_out;
  logic        pulse_valid;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow_err;
  logic        late_err;

  typedef struct {
    logic [31:0] t;
    logic [39:0] p;
  } entry_t;

  entry_t      modelQ[$];
  logic        expValid = 1'b0;
  logic [39:0] expOut = '0;
  logic        expOverflow = 1'b0;
  logic        expLate = 1'b0;
  logic [31:0] qclkNow = '0;
  int          checks = 0;
  int          errors = 0;

  pulse_cmd_queue dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_in_i       (cmd_in),
    .cstrobe_i      (cstrobe),
    .qclk_i         (qclk),
    .flush_i        (flush),
    .pulse_out_o    (pulse_out),
    .pulse_valid_o  (pulse_valid),
    .full_o         (full),
    .empty_o        (empty),
    .count_o        (count),
    .overflow_err_o (overflow_err),
    .late_err_o     (late_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("pulse_valid", 72'(pulse_valid), 72'(expValid));
    checkOutput("pulse_out", 72'(pulse_out), 72'(expOut));
    checkOutput("count", 72'(count), 72'(modelQ.size()));
    checkOutput("full", 72'(full), 72'(modelQ.size() == 8));
    checkOutput("empty", 72'(empty), 72'(modelQ.size() == 0));
    checkOutput("overflow_err", 72'(overflow_err), 72'(expOverflow));
    checkOutput("late_err", 72'(late_err), 72'(expLate));
  endtask

  task automatic modelReset();
    modelQ.delete();
    expValid    = 1'b0;
    expOut      = '0;
    expOverflow = 1'b0;
    expLate     = 1'b0;
  endtask

  // One clock of the reference: release/drop the head by signed time distance, then accept a push.
  task automatic modelStep(input logic cs, input logic [31:0] t, input logic [39:0] p,
                           input logic fl, input logic [31:0] qc);
    logic signed [31:0] d;
    entry_t e;
    expValid = 1'b0;
    if (fl) begin
      modelQ.delete();
    end else begin
      if (modelQ.size() > 0) begin
        d = $signed(modelQ[0].t - qc);
        if (d == 0) begin
          expValid = 1'b1;
          expOut   = modelQ[0].p;
          void'(modelQ.pop_front());
        end else if (d < 0) begin
          expLate = 1'b1;
`ifdef PULSE_LATE_ISSUE_EN
          expValid = 1'b1;
          expOut   = modelQ[0].p;
`endif
          void'(modelQ.pop_front());
        end
      end
      if (cs) begin
        if (modelQ.size() < 8) begin
          e.t = t;
          e.p = p;
          modelQ.push_back(e);
        end else begin
          expOverflow = 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic cs, input logic [31:0] t, input logic [39:0] p, input logic fl);
    cstrobe = cs;
    cmd_in  = {t, p};
    flush   = fl;
    qclk    = qclkNow;
    @(posedge clk);
    modelStep(cs, t, p, fl, qclkNow);
    qclkNow = qclkNow + 1;
    #1;
    checkAll();
    @(negedge clk);
    cstrobe = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 32'd0, 40'd0, 1'b0);
  endtask

  // Reset is asserted between clock edges so the outputs must clear asynchronously.
  task automatic doReset();
    cstrobe = 1'b0;
    flush   = 1'b0;
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkAll();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] t;
    logic        cs;
    logic        fl;

    @(negedge clk);
    @(negedge clk);
    modelReset();
    checkAll();
    reset = 1'b1;

    // Single entry released exactly at its trigger time.
    qclkNow = 32'd90;
    applyStimulus(1'b1, 32'd100, 40'hA5, 1'b0);
    idle(15);

    // Full queue: a push in the cycle the head issues is accepted without overflow.
    doReset();
    qclkNow = 32'd150;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'd200 + 32'(i), 40'h100 + 40'(i), 1'b0);
    idle(200 - 158);
    applyStimulus(1'b1, 32'd210, 40'h77, 1'b0);
    idle(20);

    // Ninth push while full and not popping is dropped.
    doReset();
    qclkNow = 32'd142;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'd200 + 32'(i), 40'h200 + 40'(i), 1'b0);
    applyStimulus(1'b1, 32'd208, 40'h2FF, 1'b0);
    idle(70);

    // Trigger time across the qclk wrap.
    doReset();
    qclkNow = 32'hFFFF_FFFE;
    applyStimulus(1'b1, 32'h0000_0002, 40'h5A, 1'b0);
    idle(8);

    // Entry whose time has already passed.
    qclkNow = 32'd60;
    applyStimulus(1'b1, 32'd50, 40'h33, 1'b0);
    idle(4);

    // Flush with a simultaneous strobe, then an asynchronous reset mid-queue.
    doReset();
    qclkNow = 32'd1000;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'd1100 + 32'(i), 40'h400 + 40'(i), 1'b0);
    applyStimulus(1'b1, 32'd1200, 40'h4FF, 1'b1);
    idle(3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'd1100 + 32'(i), 40'h500 + 40'(i), 1'b0);
    doReset();
    idle(2);

    // Random traffic with occasional late entries, flushes and qclk jumps.
    qclkNow = $urandom;
    for (int n = 0; n < 700; n++) begin
      cs = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < 8) t = qclkNow - 32'($urandom_range(0, 5));
      else t = qclkNow + 32'd1 + 32'($urandom_range(0, 25));
      if ($urandom_range(0, 99) == 0) qclkNow = qclkNow + 32'($urandom_range(0, 10));
      applyStimulus(cs, t, {8'h00, 32'($urandom)}, fl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
